// File: rtl/apb_uart_ctrl.sv
// APB slave fronting a UART PHY stream: TX/RX FIFOs, prescale, control/status,
// sticky RX error flags and a registered level interrupt.
module apb_uart_ctrl #(
  parameter int          DATA_W       = 8,
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] PRESCALE_RST = 16'd108
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq,
  output logic [DATA_W-1:0] phy_tx_data,
  output logic              phy_tx_valid,
  input  logic              phy_tx_ready,
  input  logic [DATA_W-1:0] phy_rx_data,
  input  logic              phy_rx_valid,
  input  logic              phy_rx_ferr,
  output logic [15:0]       phy_prescale
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TAW-1:0]    tx_wp, tx_rp;
  logic [RAW-1:0]    rx_wp, rx_rp;
  logic [TCW-1:0]    tx_cnt;
  logic [RCW-1:0]    rx_cnt;

  logic        tx_en, rx_en, irq_rx_en, irq_tx_en, irq_err_en;
  logic [7:0]  rx_thresh;
  logic [15:0] prescale;
  logic        rx_overrun, rx_ferr;

  logic xfer, acc_data, acc_stat, acc_ctrl, acc_pre, acc_unmap;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_take, ovr_set, ferr_set;
  logic [1:0]  w1c;
  logic [7:0]  tx_cnt8, rx_cnt8, thresh_eff;
  logic [31:0] status_word, ctrl_word;
  logic        irq_next;
  logic        unused_bits;

  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

  assign xfer      = PSEL & PENABLE;
  assign acc_data  = xfer & (PADDR[4:2] == 3'd0);
  assign acc_stat  = xfer & (PADDR[4:2] == 3'd1);
  assign acc_ctrl  = xfer & (PADDR[4:2] == 3'd2);
  assign acc_pre   = xfer & (PADDR[4:2] == 3'd3);
  assign acc_unmap = xfer & PADDR[4];

  assign tx_full  = (tx_cnt == TCW'(TX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == RCW'(RX_DEPTH));
  assign rx_empty = (rx_cnt == '0);

  // PHY TX handshake: a character moves on any edge where phy_tx_valid and
  // phy_tx_ready are both high; phy_tx_valid never depends on phy_tx_ready.
  assign phy_tx_valid = tx_en & ~tx_empty;
  assign phy_tx_data  = tx_mem[tx_rp];
  assign phy_prescale = prescale;

  assign tx_push  = acc_data & PWRITE & ~tx_full;
  assign tx_pop   = phy_tx_valid & phy_tx_ready;
  assign rx_pop   = acc_data & ~PWRITE & ~rx_empty;
  // Fullness is judged before the edge, so a same-cycle APB pop never makes room.
  assign rx_take  = phy_rx_valid & rx_en;
  assign rx_push  = rx_take & ~rx_full;
  assign ovr_set  = rx_take & rx_full;
  assign ferr_set = rx_take & phy_rx_ferr;
  assign w1c      = (acc_stat & PWRITE) ? PWDATA[5:4] : 2'b00;

  assign PREADY  = 1'b1;
  assign PSLVERR = acc_unmap | (acc_data & PWRITE & tx_full) | (acc_data & ~PWRITE & rx_empty);

  assign tx_cnt8     = 8'(tx_cnt);
  assign rx_cnt8     = 8'(rx_cnt);
  assign status_word = {8'd0, rx_cnt8, tx_cnt8, 2'b00, rx_ferr, rx_overrun,
                        rx_full, tx_empty, ~rx_empty, ~tx_full};
  assign ctrl_word   = {16'd0, rx_thresh, 3'b000, irq_err_en, irq_tx_en, irq_rx_en, rx_en, tx_en};

  always_comb begin
    PRDATA = '0;
    case (PADDR[4:2])
      3'd0: if (!rx_empty) PRDATA = 32'(rx_mem[rx_rp]);
      3'd1: PRDATA = status_word;
      3'd2: PRDATA = ctrl_word;
      3'd3: PRDATA = {16'd0, prescale};
      default: PRDATA = '0;
    endcase
  end

  // A threshold of 0 behaves as 1 so the RX interrupt never fires on an empty FIFO.
  assign thresh_eff = (rx_thresh == 8'd0) ? 8'd1 : rx_thresh;
  assign irq_next   = (irq_rx_en & (rx_cnt8 >= thresh_eff))
                    | (irq_tx_en & tx_empty)
                    | (irq_err_en & (rx_overrun | rx_ferr));

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wp] <= PWDATA[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= phy_rx_data;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      tx_cnt     <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_cnt     <= '0;
      tx_en      <= 1'b1;
      rx_en      <= 1'b1;
      irq_rx_en  <= 1'b0;
      irq_tx_en  <= 1'b0;
      irq_err_en <= 1'b0;
      rx_thresh  <= 8'd1;
      prescale   <= PRESCALE_RST;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TAW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + TCW'(1);
        2'b01:   tx_cnt <= tx_cnt - TCW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (rx_push) rx_wp <= rx_wp + RAW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + RCW'(1);
        2'b01:   rx_cnt <= rx_cnt - RCW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (acc_ctrl && PWRITE) begin
        tx_en      <= PWDATA[0];
        rx_en      <= PWDATA[1];
        irq_rx_en  <= PWDATA[2];
        irq_tx_en  <= PWDATA[3];
        irq_err_en <= PWDATA[4];
        rx_thresh  <= PWDATA[15:8];
      end
      if (acc_pre && PWRITE) prescale <= PWDATA[15:0];
      // Set has priority over a write-one-to-clear on the same edge.
      rx_overrun <= ovr_set  | (rx_overrun & ~w1c[0]);
      rx_ferr    <= ferr_set | (rx_ferr & ~w1c[1]);
      irq        <= irq_next;
    end
  end

endmodule
